// File: rtl/pipe_reg.sv
// pipe_reg: WIDTH-bit, DEPTH-stage stallable register pipeline with a
// valid/ready handshake. Empty stages keep advancing while downstream stages
// are stalled, so bubbles collapse. It also provides a synchronous flush, a
// registered occupancy count, and data registers that reset to INIT.
module pipe_reg #(
  parameter int              WIDTH = 8,
  parameter int              DEPTH = 3,
  parameter logic [WIDTH-1:0] INIT = '0,
  localparam int             CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  // Stage 0 is the input side. Stage DEPTH-1 drives the outputs.
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  // go[i]: stage i may take a new value this edge.
  logic [DEPTH-1:0] go;
  logic             in_acc;

  // Move-enable chain, evaluated from the output side back toward the input.
  // A stage may move if it is empty or if the stage after it can move.
  always_comb begin
    logic chain;
    chain = out_ready;
    go    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain = ~vld_q[i] | chain;
      go[i] = chain;
    end
  end

  assign in_ready = go[0] & ~flush;
  assign in_acc   = in_valid & in_ready;

  // Next-state for the stage valids and data. Data loads only when a valid
  // word arrives, so bubbles do not toggle the data registers. Flush clears
  // the valids only and leaves the data untouched.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush) begin
      vld_d = '0;
    end else begin
      if (go[0]) begin
        vld_d[0] = in_acc;
        if (in_acc) begin
          data_d[0] = in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (go[i]) begin
          vld_d[i] = vld_q[i-1];
          if (vld_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
    end
  end

  // Occupancy after the coming edge is the population count of the next valids.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CNT_W'(vld_d[i]);
    end
  end

  // State registers. Asynchronous reset empties the pipe and preloads the data with INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= INIT;
      end
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: doc/pipe_reg.md
Name: pipe_reg

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline with a valid/ready handshake.
- Stalled stages hold their data; bubbles collapse, so an empty stage absorbs data while stages downstream of it are stalled.
- Adds synchronous flush, occupancy count and reset-initialised data.
- Used between game-logic and video/timing paths wherever a fixed, stallable delay is needed.

Parameters:
- WIDTH, 8, data width in bits (≥1).
- DEPTH, 3, number of register stages (≥1); unstalled latency in cycles.
- INIT, 0, value loaded into every data register on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all stage valids.
- in_data  input  WIDTH  upstream data.
- in_valid  input  1  upstream data is valid.
- in_ready  output  1  pipeline accepts in_data this cycle.
- out_data  output  WIDTH  last-stage data.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- State per stage i (0 = input side, DEPTH-1 = output side): v[i] (valid bit) and d[i] (data, WIDTH bits).
- Reset (rst_n low, asynchronous): all v[i]=0, all d[i]=INIT, count=0. Resulting outputs: out_valid=0, out_data=INIT, in_ready=1.
  - Reset deassertion takes effect at the next clk edge.
  - Reset asserted mid-stream discards all in-flight data immediately.
- Stage move rule (combinational, evaluated from the output side back):
  - go[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - go[i] = ~v[i] | go[i+1].
- in_ready = go[0] & ~flush.
- On a clk edge where go[i] is 1:
  - stage i loads from stage i-1; stage 0 loads from the input.
  - v[0] <= in_valid & in_ready.
  - d[i] loads only when the incoming valid is 1. On a bubble, d[i] holds its value, to save toggles.
- On a clk edge where go[i] is 0: stage i holds both v[i] and d[i].
- Output transfer: occurs when out_valid & out_ready.
- Input transfer: occurs when in_valid & in_ready.
- Latency: with out_ready held high, data presented at edge k appears on out_data after edge k+DEPTH-1, i.e. DEPTH register stages.
- Throughput: one word per cycle sustained. No word is lost or duplicated under any out_ready pattern.
- Bubble collapse: when out_ready=0, upstream empty stages still advance. in_ready stays 1 until all DEPTH stages are valid.
- Full: all v=1 and out_ready=0 → in_ready=0, all stages hold.
- Full with out_ready=1: in_ready=1 (pass-through via the combinational chain); count stays DEPTH.
- Flush (sampled at a clk edge): all v[i] <= 0; d unchanged.
  - in_ready=0 while flush is high, so input is not accepted.
  - out_valid may be 1 in the flush cycle. An out_ready handshake in that cycle counts as a completed transfer.
- count: registered; equals the number of v[i]=1 after each edge; reset value 0; range 0..DEPTH.
- out_data is meaningful only when out_valid=1. The bench must not check out_data when out_valid=0, except INIT after reset.
- Inputs are assumed synchronous to clk. No CDC is performed inside this block.

Test Plan:
- Reset: WIDTH=8, DEPTH=3, INIT=8'hA5; pulse rst_n low mid-cycle → out_valid=0, out_data=8'hA5, count=0, in_ready=1 immediately, before any clk edge.
- Streaming: out_ready=1; drive 8'h01..8'h10 on consecutive cycles with in_valid=1 → 8'h01 appears with out_valid=1 three edges after acceptance; 16 words in order, no gaps; count=3 in steady state.
- Fill/stall: out_ready=0; drive 8'h11,8'h22,8'h33,8'h44 → first three accepted, count=3, in_ready=0; 8'h44 held. Raise out_ready → outputs in order 11,22,33,44.
- Bubble collapse: send 8'h5A, idle 2 cycles with out_ready=0, then send 8'h6B → both accepted, count=2, in_ready=1.
- Flush: pipeline holding 3 words, assert flush 1 cycle with in_valid=1, in_data=8'h77 → next cycle count=0, out_valid=0; 8'h77 never emerges.
- Random back-pressure: random in_valid/out_ready for 10k cycles, DEPTH=1 and DEPTH=5 → scoreboard shows exact in-order delivery, no loss/duplication, count always matches the model.
